// File: rtl/cond_pkg.sv
// Shared definitions for ARM condition evaluation: condition codes, NZCV bit
// positions and flag write-group bounds.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  // Lowest flag bit index owned by write group g.
  function automatic int grp_lo(input int g, input int ngroups);
    return (g * 4) / ngroups;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator: cond + NZCV -> condex.
// Kept standalone so the pipelined core can reuse it.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v;

  assign n = flags[N_IDX];
  assign z = flags[Z_IDX];
  assign c = flags[C_IDX];
  assign v = flags[V_IDX];

  always_comb begin
    condex = 1'b1;
    case (cond_e'(cond))
      EQ: condex = z;
      NE: condex = ~z;
      CS: condex = c;
      CC: condex = ~c;
      MI: condex = n;
      PL: condex = ~n;
      VS: condex = v;
      VC: condex = ~v;
      HI: condex = c & ~z;
      LS: condex = ~c | z;
      GE: condex = (n == v);
      LT: condex = (n != v);
      GT: condex = ~z & (n == v);
      LE: condex = z | (n != v);
      AL: condex = 1'b1;
      NV: condex = 1'b1;
      default: condex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit_mc.sv
// Conditional-execution unit for the multicycle ARM datapath: NZCV flags with
// grouped writes, shadow flags, latched condex, write gating and skip counter.
module cond_unit_mc
  import cond_pkg::*;
#(
  parameter int NGROUPS      = 2,
  parameter int DELAY_CONDEX = 1,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         cond,
  input  logic [3:0]         aluflags,
  input  logic [NGROUPS-1:0] flagw,
  input  logic               pcs,
  input  logic               regw,
  input  logic               memw,
  input  logic               eval,
  input  logic               stall,
  input  logic               flush,
  input  logic               save_flags,
  input  logic               restore_flags,
  output logic               pcsrc,
  output logic               regwrite,
  output logic               memwrite,
  output logic [3:0]         flags_q,
  output logic               condex_q,
  output logic [CNT_W-1:0]   skip_count
);

  localparam int GW = 4 / NGROUPS;

  if (4 % NGROUPS != 0) begin : g_bad_ngroups
    $error("cond_unit_mc: NGROUPS must divide 4");
  end

  logic       condex_c;
  logic       cx;
  logic       wr_ok;
  logic       gate;
  logic [3:0] wmask;
  logic [3:0] shadow_q;
  logic [3:0] flags_nxt;

  cond_eval u_cond_eval (
    .cond   (cond),
    .flags  (flags_q),
    .condex (condex_c)
  );

  // Later instruction states see the condex captured at eval, so a
  // flag-setting instruction is not gated by its own new flags.
  always_comb begin
    if (DELAY_CONDEX != 0) cx = eval ? condex_c : condex_q;
    else                   cx = condex_c;
  end

  assign wr_ok = cx & ~stall & ~flush;
  assign gate  = wr_ok & ~rst;

  assign pcsrc    = pcs  & gate;
  assign regwrite = regw & gate;
  assign memwrite = memw & gate;

  for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
    localparam int LO = grp_lo(g, NGROUPS);
    assign wmask[LO +: GW] = {GW{flagw[g] & wr_ok}};
  end

  assign flags_nxt = restore_flags ? shadow_q
                                   : ((flags_q & ~wmask) | (aluflags & wmask));

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q    <= '0;
      shadow_q   <= '0;
      condex_q   <= 1'b0;
      skip_count <= '0;
    end else if (!stall) begin
      // shadow samples the pre-update flags, so save+restore is a swap
      if (save_flags) shadow_q <= flags_q;
      flags_q <= flags_nxt;
      if (flush)     condex_q <= 1'b0;
      else if (eval) condex_q <= condex_c;
      if (eval && !condex_c && !flush && (skip_count != {CNT_W{1'b1}}))
        skip_count <= skip_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cond_unit_mc.sv
// Self-checking bench for cond_unit_mc: condition table, latched condex,
// grouped flag writes, shadow swap, stall/flush and saturating skip count.
module tb_cond_unit_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cond, aluflags;
  logic [1:0]  flagw;
  logic [3:0]  flagw4;
  logic        pcs, regw, memw, eval, stall, flush, save_flags, restore_flags;
  logic        pcsrc, regwrite, memwrite, condex_q;
  logic [3:0]  flags_q;
  logic [2:0]  skip_count;
  logic        pcsrc4, regwrite4, memwrite4, condex_q4;
  logic [3:0]  flags_q4;
  logic [15:0] skip_count4;

  logic [15:0] sb[$];
  logic [15:0] exp;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cond_unit_mc #(.NGROUPS(2), .DELAY_CONDEX(1), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .cond(cond), .aluflags(aluflags), .flagw(flagw),
    .pcs(pcs), .regw(regw), .memw(memw), .eval(eval), .stall(stall),
    .flush(flush), .save_flags(save_flags), .restore_flags(restore_flags),
    .pcsrc(pcsrc), .regwrite(regwrite), .memwrite(memwrite),
    .flags_q(flags_q), .condex_q(condex_q), .skip_count(skip_count)
  );

  cond_unit_mc #(.NGROUPS(4), .DELAY_CONDEX(1), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .cond(cond), .aluflags(aluflags), .flagw(flagw4),
    .pcs(pcs), .regw(regw), .memw(memw), .eval(eval), .stall(stall),
    .flush(flush), .save_flags(save_flags), .restore_flags(restore_flags),
    .pcsrc(pcsrc4), .regwrite(regwrite4), .memwrite(memwrite4),
    .flags_q(flags_q4), .condex_q(condex_q4), .skip_count(skip_count4)
  );

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    if (c == 4'd0)  return z;
    if (c == 4'd1)  return !z;
    if (c == 4'd2)  return cf;
    if (c == 4'd3)  return !cf;
    if (c == 4'd4)  return n;
    if (c == 4'd5)  return !n;
    if (c == 4'd6)  return v;
    if (c == 4'd7)  return !v;
    if (c == 4'd8)  return cf && !z;
    if (c == 4'd9)  return !cf || z;
    if (c == 4'd10) return n == v;
    if (c == 4'd11) return n != v;
    if (c == 4'd12) return !z && (n == v);
    if (c == 4'd13) return z || (n != v);
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; cond = 4'd0; aluflags = 4'd0; flagw = 2'b00; flagw4 = 4'b0000;
    pcs = 0; regw = 0; memw = 0; eval = 0; stall = 0; flush = 0;
    save_flags = 0; restore_flags = 0;
  endtask

  task automatic set_flags(input logic [3:0] v);
    cond = 4'b1110; eval = 1; flagw = 2'b11; flagw4 = 4'b1111; aluflags = v;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1; regw = 1; pcs = 1; memw = 1; eval = 1; cond = 4'b1110;
    tick();
    sb.push_back(16'h0);
    exp = sb.pop_front(); checks++;
    if ({pcsrc, regwrite, memwrite} !== exp[2:0]) begin
      errors++; $display("FAIL reset_outputs got=%b want=%b", {pcsrc, regwrite, memwrite}, exp[2:0]);
    end
    sb.push_back(16'h0);
    exp = sb.pop_front(); checks++;
    if ({flags_q, condex_q, skip_count} !== exp[7:0]) begin
      errors++; $display("FAIL reset_state got=%b want=%b", {flags_q, condex_q, skip_count}, exp[7:0]);
    end
    idle();
  endtask

  task automatic test_cond_table();
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      sb.push_back(16'(f));
      exp = sb.pop_front(); checks++;
      if (flags_q !== exp[3:0]) begin
        errors++; $display("FAIL table_flags got=%b want=%b", flags_q, exp[3:0]);
      end
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c); regw = 1; eval = 1;
        sb.push_back({15'd0, ref_cond(4'(c), 4'(f))});
        #1;
        exp = sb.pop_front(); checks++;
        if (regwrite !== exp[0]) begin
          errors++; $display("FAIL cond_%0d_flags_%b got=%b want=%b", c, 4'(f), regwrite, exp[0]);
        end
      end
      idle();
    end
  endtask

  task automatic test_delayed_condex();
    set_flags(4'b0000);
    cond = 4'b0000; eval = 1; flagw = 2'b11; aluflags = 4'b0100;
    tick();
    idle(); regw = 1;
    sb.push_back(16'h0);
    #1;
    exp = sb.pop_front(); checks++;
    if ({flags_q, regwrite} !== exp[4:0]) begin
      errors++; $display("FAIL eq_nowrite got=%b want=%b", {flags_q, regwrite}, exp[4:0]);
    end
    idle();
    set_flags(4'b0000);
    cond = 4'b0001; eval = 1; flagw = 2'b11; aluflags = 4'b0100;
    tick();
    idle(); regw = 1; cond = 4'b0001;
    sb.push_back({11'd0, 4'b0100, 1'b1});
    #1;
    exp = sb.pop_front(); checks++;
    if ({flags_q, regwrite} !== exp[4:0]) begin
      errors++; $display("FAIL ne_latched got=%b want=%b", {flags_q, regwrite}, exp[4:0]);
    end
    idle();
  endtask

  task automatic test_groups();
    set_flags(4'b0000);
    cond = 4'b1110; eval = 1; flagw = 2'b01; flagw4 = 4'b1000; aluflags = 4'b1111;
    sb.push_back(16'b0011);
    sb.push_back(16'b1000);
    tick();
    exp = sb.pop_front(); checks++;
    if (flags_q !== exp[3:0]) begin
      errors++; $display("FAIL group2 got=%b want=%b", flags_q, exp[3:0]);
    end
    exp = sb.pop_front(); checks++;
    if (flags_q4 !== exp[3:0]) begin
      errors++; $display("FAIL group4 got=%b want=%b", flags_q4, exp[3:0]);
    end
    idle();
  endtask

  task automatic test_shadow();
    set_flags(4'b1010);
    save_flags = 1;
    tick();
    idle();
    set_flags(4'b0101);
    save_flags = 1; restore_flags = 1;
    sb.push_back(16'b1010);
    tick();
    exp = sb.pop_front(); checks++;
    if (flags_q !== exp[3:0]) begin
      errors++; $display("FAIL swap got=%b want=%b", flags_q, exp[3:0]);
    end
    idle();
    restore_flags = 1; flagw = 2'b11; aluflags = 4'b1111; cond = 4'b1110; eval = 1;
    sb.push_back(16'b0101);
    tick();
    exp = sb.pop_front(); checks++;
    if (flags_q !== exp[3:0]) begin
      errors++; $display("FAIL restore_wins got=%b want=%b", flags_q, exp[3:0]);
    end
    idle();
  endtask

  task automatic test_stall_flush();
    rst = 1;
    tick();
    idle();
    set_flags(4'b0011);
    stall = 1; eval = 1; cond = 4'b0000; flagw = 2'b11; aluflags = 4'b1100;
    save_flags = 1; pcs = 1; regw = 1; memw = 1;
    sb.push_back(16'h0);
    #1;
    exp = sb.pop_front(); checks++;
    if ({pcsrc, regwrite, memwrite} !== exp[2:0]) begin
      errors++; $display("FAIL stall_outputs got=%b want=%b", {pcsrc, regwrite, memwrite}, exp[2:0]);
    end
    sb.push_back({8'd0, 4'b0011, 1'b1, 3'd0});
    tick();
    exp = sb.pop_front(); checks++;
    if ({flags_q, condex_q, skip_count} !== exp[7:0]) begin
      errors++; $display("FAIL stall_state got=%b want=%b", {flags_q, condex_q, skip_count}, exp[7:0]);
    end
    idle();
    restore_flags = 1;
    sb.push_back(16'b0000);
    tick();
    exp = sb.pop_front(); checks++;
    if (flags_q !== exp[3:0]) begin
      errors++; $display("FAIL stall_no_save got=%b want=%b", flags_q, exp[3:0]);
    end
    idle();
    eval = 1; cond = 4'b1110; memw = 1;
    sb.push_back(16'h1);
    #1;
    exp = sb.pop_front(); checks++;
    if (memwrite !== exp[0]) begin
      errors++; $display("FAIL eval_memwrite got=%b want=%b", memwrite, exp[0]);
    end
    memw = 0;
    tick();
    idle(); flush = 1; memw = 1;
    sb.push_back(16'h0);
    #1;
    exp = sb.pop_front(); checks++;
    if (memwrite !== exp[0]) begin
      errors++; $display("FAIL flush_memwrite got=%b want=%b", memwrite, exp[0]);
    end
    tick();
    flush = 0;
    sb.push_back(16'h0);
    #1;
    exp = sb.pop_front(); checks++;
    if ({condex_q, memwrite} !== exp[1:0]) begin
      errors++; $display("FAIL after_flush got=%b want=%b", {condex_q, memwrite}, exp[1:0]);
    end
    idle();
  endtask

  task automatic test_skip_count();
    int exp_cnt;
    rst = 1;
    tick();
    idle();
    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      eval = 1; cond = 4'b0000;
      exp_cnt = (exp_cnt < 7) ? exp_cnt + 1 : 7;
      sb.push_back(16'(exp_cnt));
      tick();
      exp = sb.pop_front(); checks++;
      if (skip_count !== exp[2:0]) begin
        errors++; $display("FAIL skip_%0d got=%0d want=%0d", i, skip_count, exp[2:0]);
      end
    end
    rst = 1;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      eval = 1; cond = 4'b0000;
      tick();
    end
    sb.push_back(16'd3);
    exp = sb.pop_front(); checks++;
    if (skip_count !== exp[2:0]) begin
      errors++; $display("FAIL skip_mid got=%0d want=%0d", skip_count, exp[2:0]);
    end
    rst = 1; regw = 1;
    sb.push_back(16'd0);
    tick();
    exp = sb.pop_front(); checks++;
    if ({regwrite, skip_count} !== exp[3:0]) begin
      errors++; $display("FAIL skip_rst got=%b want=%b", {regwrite, skip_count}, exp[3:0]);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_cond_table();
    test_delayed_condex();
    test_groups();
    test_shadow();
    test_stall_flush();
    test_skip_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
